// File: rtl/bank_xbar_rtn_buf.sv
//==============================================================================
// Module  : bank_xbar_rtn_buf
// Brief   : Per-channel return FIFOs between the bank SRAM controller and the
//           crossbar, with credit pulses. Optional same-cycle bypass when
//           BANK_XBAR_RTN_BYPASS_EN is defined.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module bank_xbar_rtn_buf #(
  parameter int CH_NUM  = 3,
  parameter int CH_ID_W = 2,
  parameter int ROB_W   = 3,
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sc_xbar_valid_i,
  output logic                     sc_xbar_ready_o,
  input  logic [CH_ID_W-1:0]       sc_xbar_channel_id_i,
  input  logic [ROB_W-1:0]         sc_xbar_rob_num_i,
  input  logic [DATA_W-1:0]        sc_xbar_data_i,
  output logic [CH_NUM-1:0]        xbar_valid_o,
  input  logic [CH_NUM-1:0]        xbar_ready_i,
  output logic [CH_NUM*ROB_W-1:0]  xbar_rob_num_o,
  output logic [CH_NUM*DATA_W-1:0] xbar_data_o,
  output logic [CH_NUM-1:0]        xbar_isu_credit_o,
  output logic                     err_bad_ch_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROB_W + DATA_W;

  logic              legal_ch;
  logic [CH_NUM-1:0] full;
  logic              sel_full;
  logic              accept;
  logic              err_bad_ch;
  logic [ENT_W-1:0]  in_entry;

  assign legal_ch = int'(sc_xbar_channel_id_i) < CH_NUM;
  assign in_entry = {sc_xbar_rob_num_i, sc_xbar_data_i};

  always_comb begin
    sel_full = 1'b0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (sc_xbar_channel_id_i == CH_ID_W'(c)) begin
        sel_full = full[c];
      end
    end
  end

  // Illegal ids are always accepted so a bad beat can never wedge the port.
  assign sc_xbar_ready_o = !rst_i && (!legal_ch || !sel_full);
  assign accept          = sc_xbar_valid_i && sc_xbar_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_bad_ch <= 1'b0;
    end else if (accept && !legal_ch) begin
      err_bad_ch <= 1'b1;
    end
  end

  assign err_bad_ch_o = err_bad_ch;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             credit;
    logic             hit;
    logic             byp;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] out_entry;

    assign not_empty = count != '0;
    assign full[c]   = count == CNT_W'(DEPTH);
    assign hit       = accept && legal_ch && (sc_xbar_channel_id_i == CH_ID_W'(c));

`ifdef BANK_XBAR_RTN_BYPASS_EN
    // Beat for an idle, ready channel skips the FIFO entirely.
    assign byp = hit && !not_empty && xbar_ready_i[c];
`else
    assign byp = 1'b0;
`endif

    assign push = hit && !byp;
    assign pop  = not_empty && xbar_ready_i[c];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        credit <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count  <= count + CNT_W'(push) - CNT_W'(pop);
        credit <= pop || byp;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
      end
    end

    assign head = mem[rd_ptr];

    always_comb begin
      out_entry = '0;
      if (byp) begin
        out_entry = in_entry;
      end else if (not_empty) begin
        out_entry = head;
      end
    end

    assign xbar_valid_o[c]                   = not_empty || byp;
    assign xbar_rob_num_o[c*ROB_W +: ROB_W]  = out_entry[ENT_W-1 -: ROB_W];
    assign xbar_data_o[c*DATA_W +: DATA_W]   = out_entry[DATA_W-1:0];
    assign xbar_isu_credit_o[c]              = credit;
  end

endmodule

`default_nettype wire

// File: tb/tb_bank_xbar_rtn_buf.sv
//==============================================================================
// Module  : tb_bank_xbar_rtn_buf
// Brief   : Directed scoreboard bench for bank_xbar_rtn_buf.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bank_xbar_rtn_buf;

  localparam int CH = 3;
  localparam int IDW = 2;
  localparam int RW = 3;
  localparam int DW = 128;
  localparam int D = 4;

  typedef logic [RW+DW-1:0] ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic [IDW-1:0]    chid = '0;
  logic [RW-1:0]     rob_in = '0;
  logic [DW-1:0]     data_in = '0;
  logic [CH-1:0]     valid_out;
  logic [CH-1:0]     xrdy = '1;
  logic [CH*RW-1:0]  rob_out;
  logic [CH*DW-1:0]  data_out;
  logic [CH-1:0]     credit;
  logic              err;

  ent_t          q [CH][$];
  int            pass_cnt = 0;
  int            total = 0;
  logic          err_m = 1'b0;
  logic [CH-1:0] cred_exp = '0;

  bank_xbar_rtn_buf #(
    .CH_NUM(CH), .CH_ID_W(IDW), .ROB_W(RW), .DATA_W(DW), .DEPTH(D)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .sc_xbar_valid_i     (valid_in),
    .sc_xbar_ready_o     (ready_out),
    .sc_xbar_channel_id_i(chid),
    .sc_xbar_rob_num_i   (rob_in),
    .sc_xbar_data_i      (data_in),
    .xbar_valid_o        (valid_out),
    .xbar_ready_i        (xrdy),
    .xbar_rob_num_o      (rob_out),
    .xbar_data_o         (data_out),
    .xbar_isu_credit_o   (credit),
    .err_bad_ch_o        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] pat(int c, int rob);
    logic [7:0] tag;
    tag = 8'(c * 16 + rob);
    return {4{tag, 24'hC0FFEE}};
  endfunction

  task automatic drive(bit v, int ch, int rob, logic [DW-1:0] d);
    valid_in = v;
    chid     = IDW'(ch);
    rob_in   = RW'(rob);
    data_in  = d;
  endtask

  // One clock: handshakes are evaluated at the falling edge, credits after the rising edge.
  task automatic tick();
    int   ch;
    bit   legal, exp_r, acc, exp_v;
    int   sb [CH];
    ent_t head;
    @(negedge clk);
    ch    = int'(chid);
    legal = ch < CH;
    exp_r = 1'b1;
    if (legal) exp_r = q[ch].size() < D;
    check("sc_ready", DW'(ready_out), DW'(exp_r));
    check("err_bad_ch", DW'(err), DW'(err_m));
    acc = valid_in && exp_r;
    for (int c = 0; c < CH; c++) sb[c] = q[c].size();
    if (acc && legal) q[ch].push_back({rob_in, data_in});
    cred_exp = '0;
    for (int c = 0; c < CH; c++) begin
      exp_v = sb[c] != 0;
`ifdef BANK_XBAR_RTN_BYPASS_EN
      if (acc && legal && ch == c && sb[c] == 0 && xrdy[c]) exp_v = 1'b1;
`endif
      check($sformatf("valid%0d", c), DW'(valid_out[c]), DW'(exp_v));
      if (exp_v) begin
        head = q[c][0];
        check($sformatf("rob%0d", c), DW'(rob_out[c*RW +: RW]), DW'(head[RW+DW-1 -: RW]));
        check($sformatf("data%0d", c), data_out[c*DW +: DW], head[DW-1:0]);
        if (xrdy[c]) begin
          void'(q[c].pop_front());
          cred_exp[c] = 1'b1;
        end
      end else begin
        check($sformatf("rob_idle%0d", c), DW'(rob_out[c*RW +: RW]), '0);
        check($sformatf("data_idle%0d", c), data_out[c*DW +: DW], '0);
      end
    end
    if (acc && !legal) err_m = 1'b1;
    @(posedge clk);
    #1;
    check("credit", DW'(credit), DW'(cred_exp));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", DW'(valid_out), '0);
    check("rst_credit", DW'(credit), '0);
    check("rst_err", DW'(err), '0);
    check("rst_ready", DW'(ready_out), '0);
    check("rst_data", data_out[DW-1:0], '0);
    check("rst_rob", DW'(rob_out), '0);
    rst = 1'b0;

    // Single beat on ch1, all channels ready
    drive(1, 1, 5, {16{8'hA5}});
    tick();
    drive(0, 0, 0, '0);
    tick();
    tick();

    // Fill ch0, stall the fifth beat, then a ch2 beat is accepted
    xrdy[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, i, pat(0, i));
      tick();
    end
    drive(1, 0, 4, pat(0, 4));
    tick();
    check("stall_ready", DW'(ready_out), '0);
    drive(1, 2, 6, pat(2, 6));
    tick();
    drive(0, 0, 0, '0);
    tick();

    // Drain ch0 in order with back-to-back credits
    xrdy[0] = 1'b1;
    repeat (5) tick();

    // Full ch0 with a same-cycle pop still refuses the push
    xrdy[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 4 + i, pat(0, 4 + i));
      tick();
    end
    xrdy[0] = 1'b1;
    drive(1, 0, 1, pat(0, 9));
    tick();
    xrdy[0] = 1'b0;
    tick();
    drive(0, 0, 0, '0);
    xrdy = '1;
    repeat (6) tick();

    // Illegal channel id: dropped, sticky error
    drive(1, 3, 1, pat(3, 1));
    tick();
    drive(0, 0, 0, '0);
    repeat (2) tick();

    // Reset with ch1 holding two beats
    xrdy[1] = 1'b0;
    drive(1, 1, 2, pat(1, 2));
    tick();
    drive(1, 1, 3, pat(1, 3));
    tick();
    drive(0, 0, 0, '0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", DW'(valid_out), '0);
    check("mid_rst_credit", DW'(credit), '0);
    check("mid_rst_ready", DW'(ready_out), '0);
    for (int c = 0; c < CH; c++) q[c].delete();
    err_m = 1'b0;
    cred_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    xrdy = '1;
    tick();
    drive(1, 1, 4, pat(1, 4));
    tick();
    drive(0, 0, 0, '0);
    repeat (2) tick();

    // Push into an empty, ready ch2 (same-cycle valid when bypass is built in)
    drive(1, 2, 3, pat(2, 3));
    tick();
    drive(0, 0, 0, '0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
